// File: rtl/elevator_dispatch.sv
// SCAN-policy call dispatcher driving u/d step pulses into the floor FSM.
// Optional move timeout enabled by defining ELEVATOR_DISPATCH_TIMEOUT_EN.
module elevator_dispatch #(
   parameter int unsigned FLOORS         = 4,
   parameter int unsigned DWELL_CYCLES   = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned FW             = $clog2(FLOORS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLOORS-1:0] call_req,
   input  logic [FW-1:0]     cur_floor,
   output logic              u,
   output logic              d,
   output logic              door_open,
   output logic [FLOORS-1:0] pending,
   output logic              dir_up,
   output logic              fault
);
   localparam int unsigned DCW = $clog2(DWELL_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DOOR, FAULT} state_t;

   state_t            state;
   logic [FW-1:0]     start_floor;
   logic [DCW-1:0]    dwell_cnt;
   logic [FLOORS-1:0] here_mask;
   logic [FLOORS-1:0] req_set;
   logic              here;
   logic              above;
   logic              below;
   logic              absorb;
   logic              go_up;
   logic              go_down;
   int unsigned       cf;

`ifdef ELEVATOR_DISPATCH_TIMEOUT_EN
   localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TOW-1:0] tmo_cnt;
`endif

   assign cf = 32'(cur_floor);

   always_comb begin
      here_mask = '0;
      above     = 1'b0;
      below     = 1'b0;
      for (int unsigned i = 0; i < FLOORS; i++) begin
         if (i == cf)
            here_mask[i] = 1'b1;
         else if (cf < FLOORS) begin
            if (i > cf)
               above = above | pending[i];
            else
               below = below | pending[i];
         end
      end
      here    = |(pending & here_mask);
      absorb  = (state == DOOR) && (|(call_req & here_mask));
      req_set = (state == DOOR) ? (call_req & ~here_mask) : call_req;
      // Folded priority: keep current direction while it has work, else reverse.
      go_up   = above && (dir_up || !below);
      go_down = below && !go_up;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pending     <= '0;
         u           <= 1'b0;
         d           <= 1'b0;
         door_open   <= 1'b0;
         dir_up      <= 1'b1;
         start_floor <= '0;
         dwell_cnt   <= '0;
`ifdef ELEVATOR_DISPATCH_TIMEOUT_EN
         tmo_cnt     <= '0;
         fault       <= 1'b0;
`endif
      end else begin
         u       <= 1'b0;
         d       <= 1'b0;
         pending <= pending | req_set;
         case (state)
            IDLE: begin
               if (here) begin
                  pending   <= (pending | req_set) & ~here_mask;
                  door_open <= 1'b1;
                  dwell_cnt <= DCW'(DWELL_CYCLES - 1);
                  state     <= DOOR;
               end else if (go_up || go_down) begin
                  u           <= go_up;
                  d           <= go_down;
                  dir_up      <= go_up;
                  start_floor <= cur_floor;
                  state       <= WAIT;
`ifdef ELEVATOR_DISPATCH_TIMEOUT_EN
                  tmo_cnt     <= '0;
`endif
               end
            end
            WAIT: begin
               if (cur_floor != start_floor)
                  state <= IDLE;
`ifdef ELEVATOR_DISPATCH_TIMEOUT_EN
               else if (tmo_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
                  state <= FAULT;
                  fault <= 1'b1;
               end else
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
            end
            DOOR: begin
               if (absorb)
                  dwell_cnt <= DCW'(DWELL_CYCLES - 1);
               else if (dwell_cnt == '0) begin
                  door_open <= 1'b0;
                  state     <= IDLE;
               end else
                  dwell_cnt <= dwell_cnt - 1'b1;
            end
            FAULT: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef ELEVATOR_DISPATCH_TIMEOUT_EN
   assign fault = 1'b0;
`endif

endmodule
